// File: rtl/syncram_rdport_pkg.sv
// Shared definitions for the syncram read-port client: state encoding and response buffer depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package syncram_rdport_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int RSP_DEPTH = 2;

endpackage

// File: rtl/syncram_rdport_fifo2.sv
// Two-entry response buffer holding RAM read data until the consumer takes it.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module syncram_rdport_fifo2
  import syncram_rdport_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        count_o,
  output logic [DWIDTH-1:0] head_o
);

  logic [DWIDTH-1:0] mem_q [RSP_DEPTH];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;

  // Occupancy update; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  // Pointers and occupancy; cleared so buffered data is discarded on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed when count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/syncram_rdport.sv
// Read-side client of the dual-port sync RAM: zero-fills the RAM after reset, then serves reads (SYNCRAM_RDPORT_BYPASS_EN forwards same-cycle snoop writes).
// Latency: response earliest 2 cycles after request acceptance; 1 request/cycle sustained with rsp_ready high.
// Backpressure: req_ready drops when buffered + in-flight responses (less this cycle's pop) would reach 2.
module syncram_rdport
  import syncram_rdport_pkg::*;
#(
  parameter int DWIDTH         = 16,
  parameter int AWIDTH         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic [AWIDTH-1:0] ram_raddr,
  input  logic [DWIDTH-1:0] ram_rdata,
  output logic [AWIDTH-1:0] ram_waddr,
  output logic [DWIDTH-1:0] ram_wdata,
  output logic              ram_we,
  output logic              clear_busy,
  input  logic              snoop_we,
  input  logic [AWIDTH-1:0] snoop_waddr,
  input  logic [DWIDTH-1:0] snoop_wdata
);

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              inflight_q;
  logic [1:0]        fifo_count;
  logic [DWIDTH-1:0] fifo_head;
  logic [DWIDTH-1:0] push_data;
  logic [2:0]        occ;
  logic              pop;
  logic              issue;

  // Clear sequencer: walk every address once, then hand over to read service.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_RUN;
    end
  end

  // State, clear counter and in-flight flag; a reset abandons any read in the RAM pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= issue;
    end
  end

  // Outputs are forced quiet while reset is held, whatever the registers hold.
  assign rsp_valid  = !reset && (fifo_count != 2'd0);
  assign pop        = rsp_valid && rsp_ready;
  // A pop this cycle frees a slot immediately, so rsp_ready reaches req_ready combinationally.
  assign occ        = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign req_ready  = !reset && (state_q == ST_RUN) && (occ < 3'(RSP_DEPTH));
  assign issue      = req_valid && req_ready;

  assign ram_raddr  = req_addr;
  assign ram_waddr  = cnt_q;
  assign ram_wdata  = '0;
  assign ram_we     = !reset && (state_q == ST_CLEAR);
  assign clear_busy = !reset && (state_q == ST_CLEAR);
  assign rsp_data   = fifo_head;

`ifdef SYNCRAM_RDPORT_BYPASS_EN
  logic              byp_hit_q;
  logic [DWIDTH-1:0] byp_dat_q;

  // Capture a write landing on the address being read this cycle; the RAM would return stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      byp_hit_q <= 1'b0;
      byp_dat_q <= '0;
    end else begin
      byp_hit_q <= issue && snoop_we && (snoop_waddr == req_addr);
      byp_dat_q <= snoop_wdata;
    end
  end

  assign push_data = byp_hit_q ? byp_dat_q : ram_rdata;
`else
  // Without forwarding the RAM's read-before-write result is returned as is.
  logic unused_snoop;
  assign unused_snoop = ^{snoop_we, snoop_waddr, snoop_wdata};
  assign push_data    = ram_rdata;
`endif

  syncram_rdport_fifo2 #(
    .DWIDTH (DWIDTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

endmodule

// File: tb/tb_syncram_rdport.sv
// Bench for syncram_rdport: behavioural RAM, reference memory image and a response scoreboard.
// Latency: checks the 2-cycle request-to-response path on an idle stream.
// Backpressure: exercises rsp_ready stalls, draining and random flow control.
module tb_syncram_rdport;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          clear_busy;
  logic          snoop_we;
  logic [AW-1:0] snoop_waddr;
  logic [DW-1:0] snoop_wdata;

  logic          nc_req_ready, nc_rsp_valid, nc_ram_we, nc_clear_busy;
  logic [DW-1:0] nc_rsp_data, nc_ram_wdata;
  logic [AW-1:0] nc_ram_raddr, nc_ram_waddr;
  logic          nc_we_seen = 1'b0;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          scramble;
  logic [DW-1:0] exp_q[$];
  int            iss_q[$];
  int            cyc = 0;
  int            acc_cnt = 0;
  bit            check_lat = 1'b0;
  int            n_chk = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  syncram_rdport #(.DWIDTH(DW), .AWIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .clear_busy(clear_busy),
    .snoop_we(snoop_we), .snoop_waddr(snoop_waddr), .snoop_wdata(snoop_wdata)
  );

  syncram_rdport #(.DWIDTH(DW), .AWIDTH(AW), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .reset(reset),
    .req_valid(1'b0), .req_ready(nc_req_ready), .req_addr(4'd0),
    .rsp_valid(nc_rsp_valid), .rsp_ready(1'b0), .rsp_data(nc_rsp_data),
    .ram_raddr(nc_ram_raddr), .ram_rdata(16'd0),
    .ram_waddr(nc_ram_waddr), .ram_wdata(nc_ram_wdata), .ram_we(nc_ram_we),
    .clear_busy(nc_clear_busy),
    .snoop_we(1'b0), .snoop_waddr(4'd0), .snoop_wdata(16'd0)
  );

  // Dual-port RAM: registered read, read-before-write, two write ports.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (scramble) begin
      for (int k = 0; k < DEPTH; k++) ram[k] <= 16'hDEAD ^ 16'(k);
    end else begin
      ram_rdata <= ram[ram_raddr];
      if (ram_we) ram[ram_waddr] <= ram_wdata;
      if (snoop_we) ram[snoop_waddr] <= snoop_wdata;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Scoreboard monitor: compare responses, then record newly accepted requests.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    int            ic;
    if (reset) begin
      exp_q.delete();
      iss_q.delete();
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    end else begin
      if (nc_ram_we) nc_we_seen = 1'b1;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          ic = iss_q.pop_front();
          chk("rsp_data", int'(rsp_data), int'(e));
          if (check_lat) chk("rsp_latency", cyc - ic, 2);
        end
      end
      if (req_valid && req_ready) begin
        e = ref_mem[req_addr];
`ifdef SYNCRAM_RDPORT_BYPASS_EN
        if (snoop_we && snoop_waddr == req_addr) e = snoop_wdata;
`endif
        exp_q.push_back(e);
        iss_q.push_back(cyc);
        acc_cnt++;
      end
      if (snoop_we) ref_mem[snoop_waddr] = snoop_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) step();
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d0;
    int base;
    int n;
    reset = 1'b1; scramble = 1'b1;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    snoop_we = 1'b0; snoop_waddr = '0; snoop_wdata = '0;
    step();
    scramble = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_nc_req_ready", nc_req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Zero-fill: exactly DEPTH write cycles over ascending addresses.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (i == 0) chk("nc_first_req_ready", nc_req_ready, 1);
      chk("zf_busy", clear_busy, 1);
      chk("zf_we", ram_we, 1);
      chk("zf_addr", ram_waddr, i);
      chk("zf_req_ready", req_ready, 0);
    end
    @(negedge clk);
    chk("zf_done_busy", clear_busy, 0);
    chk("zf_done_we", ram_we, 0);
    chk("zf_done_req_ready", req_ready, 1);
    step();

    // Streaming back-to-back reads after preloading through the other port.
    snoop_we = 1'b1; snoop_waddr = 4'd3; snoop_wdata = 16'hA5A5;
    step();
    snoop_waddr = 4'd4; snoop_wdata = 16'h1234;
    step();
    snoop_we = 1'b0;
    check_lat = 1'b1;
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 4'd3;
    step();
    req_addr = 4'd4;
    step();
    req_valid = 1'b0;
    drain();
    check_lat = 1'b0;

    // Backpressure: two accepted then stall; first pop frees a slot in the same cycle.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 4'd3;
    base = acc_cnt;
    step();
    req_addr = 4'd4;
    repeat (4) step();
    chk("bp_accepted", acc_cnt - base, 2);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    d0 = rsp_data;
    step();
    chk("bp_data_stable", int'(rsp_data), int'(d0));
    chk("bp_head", int'(rsp_data), 16'hA5A5);
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready_on_pop", req_ready, 1);
    step();
    req_valid = 1'b0;
    drain();
    chk("bp_total_accepted", acc_cnt - base, 3);

    // Same-cycle write/read collision on a zeroed address.
    req_valid = 1'b1; req_addr = 4'd5;
    snoop_we = 1'b1; snoop_waddr = 4'd5; snoop_wdata = 16'hBEEF;
    step();
    req_valid = 1'b0; snoop_we = 1'b0;
    drain();

    // Randomized traffic with snoop writes, some aimed at the read address.
    for (int i = 0; i < 500; i++) begin
      req_valid   = ($urandom % 4) != 0;
      req_addr    = AW'($urandom);
      rsp_ready   = ($urandom % 3) != 0;
      snoop_we    = ($urandom % 3) == 0;
      snoop_waddr = ($urandom % 2) ? req_addr : AW'($urandom);
      snoop_wdata = DW'($urandom);
      step();
    end
    req_valid = 1'b0; snoop_we = 1'b0; rsp_ready = 1'b1;
    drain();

    // Reset with two responses buffered.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 4'd7;
    repeat (3) step();
    req_valid = 1'b0;
    step();
    chk("mr_buffered", rsp_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_clear_busy", clear_busy, 1);
    chk("mr_waddr", ram_waddr, 0);
    chk("mr_req_ready", req_ready, 0);
    n = 1;
    for (int k = 0; k < 40 && clear_busy; k++) begin
      @(negedge clk);
      if (clear_busy) n++;
    end
    chk("mr_clear_cycles", n, DEPTH);
    chk("mr_rsp_after", rsp_valid, 0);
    step();
    req_valid = 1'b1; req_addr = 4'd3;
    step();
    req_valid = 1'b0;
    drain();

    chk("nc_we_never", nc_we_seen, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
